// File: rtl/instr_pkg.sv
// Field layout of the immediate-format instruction word, shared by the
// encoder and the decoder so that field placement has a single source.
package instr_pkg;

    localparam int N       = 8;
    localparam int IMM_W   = 3;
    localparam int IMM_LSB = 0;
    localparam int IMM_MSB = IMM_W - 1;
    localparam int OPC_LSB = IMM_W;
    localparam int OPC_MSB = N - 1;
    localparam int OPC_W   = N - IMM_W;

    typedef logic [OPC_W-1:0] opcode_t;
    typedef logic [N-1:0]     instr_t;

    // Places the opcode in the high field and the immediate in the low field.
    function automatic instr_t pack_instr(input opcode_t opc, input logic [IMM_W-1:0] imm_f);
        instr_t w;
        w = '0;
        w[OPC_MSB:OPC_LSB] = opc;
        w[IMM_MSB:IMM_LSB] = imm_f;
        return w;
    endfunction

endpackage

// File: rtl/instr_enc_sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head word.
// DEPTH must be a power of two; pointers wrap naturally and count carries
// the full/empty information.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [CW-1:0]    count_n;
    logic             push;
    logic             pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;

    // Next read pointer and occupancy after this cycle's push/pop.
    always_comb begin
        rd_ptr_n = rd_ptr;
        count_n  = count;
        if (pop) begin
            rd_ptr_n = rd_ptr + AW'(1);
        end
        if (push && !pop) begin
            count_n = count + CW'(1);
        end else if (!push && pop) begin
            count_n = count - CW'(1);
        end
    end

    // Storage array; contents are don't-care until referenced by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head word. When the next head is
    // the slot being written this cycle, the incoming word is forwarded into
    // the head register; the head holds its value once the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            if (count_n != '0) begin
                dout <= (push && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n];
            end
        end
    end

endmodule

// File: rtl/instr_enc.sv
// instr_enc: packs {opcode, immediate} requests into instruction words and
// streams them out through a small FIFO.
// Optional build macro IMM_RANGE_CHECK_EN: requests whose immediate does not
// fit the IMM_W-bit field are consumed but dropped, and raise a sticky err_ovf.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid does not depend on ready, and ready may be high while
// valid is low. in_ready = !full, out_valid = !empty.
import instr_pkg::*;

module instr_enc #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  opcode_t                opcode,
    input  instr_t                 imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output instr_t                 instr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_ovf
);

    logic   full;
    logic   empty;
    logic   imm_ok;
    logic   wr_en;
    instr_t word;

    assign word = pack_instr(opcode, imm[IMM_MSB:IMM_LSB]);

`ifdef IMM_RANGE_CHECK_EN
    logic err_q;

    assign imm_ok  = (imm[N-1:IMM_W] == '0);
    assign err_ovf = err_q;

    // Sticky flag: set by any accepted request whose immediate overflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (in_valid && in_ready && !imm_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_imm_hi;

    // Upper immediate bits are simply truncated in this build.
    assign unused_imm_hi = |imm[N-1:IMM_W];
    assign imm_ok        = 1'b1;
    assign err_ovf       = 1'b0;
`endif

    assign wr_en     = in_valid & imm_ok;
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    sync_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (word),
        .rd_en (out_ready),
        .dout  (instr),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_instr_enc.sv
// Bench for instr_enc: directed steps plus a random stream, checked against a
// queue of expected instruction words.
module tb_instr_enc;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] opcode;
    logic [7:0] imm;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] instr;
    logic [2:0] count;
    logic       err_ovf;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    logic [7:0] exp_q[$];
    logic       exp_err = 1'b0;

    instr_enc #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .count     (count),
        .err_ovf   (err_ovf)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [4:0] opc, input logic [7:0] im);
        opcode   = opc;
        imm      = im;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Scoreboard: checks state against the queue model, then applies the
    // handshakes that the coming rising edge will perform.
    always @(negedge clk) begin
        logic       do_pop;
        logic       do_push;
        logic       bad_imm;
        logic [7:0] e;
        if (rst) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            check("err_ovf", 32'(err_ovf), 32'(exp_err));
            do_pop  = out_ready && (exp_q.size() != 0);
            do_push = in_valid && (exp_q.size() != DEPTH);
`ifdef IMM_RANGE_CHECK_EN
            bad_imm = (imm[7:3] != 5'd0);
`else
            bad_imm = 1'b0;
`endif
            if (do_pop) begin
                e = exp_q.pop_front();
                check("instr_head", 32'(instr), 32'(e));
            end
            if (do_push) begin
                if (bad_imm) begin
                    exp_err = 1'b1;
                end else begin
                    exp_q.push_back({opcode, imm[2:0]});
                    n_acc++;
                end
            end
        end
    end

    initial begin
        int base;
        int cyc;

        // reset
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        imm       = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err", 32'(err_ovf), 32'd0);

        // single encode
        out_ready = 1'b1;
        push_word(5'b10110, 8'h05);
        check("enc_instr", 32'(instr), 32'h0B5);
        check("enc_valid", 32'(out_valid), 32'd1);
        tick();
        check("enc_drained", 32'(out_valid), 32'd0);

        // fill and backpressure
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push_word(5'(k + 8), 8'(k));
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        opcode   = 5'd31;
        imm      = 8'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fifth_refused", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_order", 32'(instr[2:0]), 32'(k));
            tick();
        end
        check("drain_empty", 32'(out_valid), 32'd0);

        // simultaneous push and pop across pointer wrap
        out_ready = 1'b0;
        push_word(5'd1, 8'd0);
        push_word(5'd2, 8'd1);
        check("sim_start", 32'(count), 32'd2);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            opcode = 5'(i);
            imm    = 8'((i + 2) % 8);
            tick();
            check("sim_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("sim_drained", 32'(count), 32'd0);

        // immediate overflow
        out_ready = 1'b0;
        push_word(5'd7, 8'h0C);
`ifdef IMM_RANGE_CHECK_EN
        check("ovf_count", 32'(count), 32'd0);
        check("ovf_valid", 32'(out_valid), 32'd0);
        check("ovf_flag", 32'(err_ovf), 32'd1);
        push_word(5'd7, 8'h02);
        check("ovf_good_count", 32'(count), 32'd1);
        check("ovf_sticky", 32'(err_ovf), 32'd1);
`else
        check("trunc_valid", 32'(out_valid), 32'd1);
        check("trunc_imm", 32'(instr[2:0]), 32'd4);
        check("trunc_instr", 32'(instr), 32'h03C);
        check("trunc_err", 32'(err_ovf), 32'd0);
`endif
        out_ready = 1'b1;
        repeat (2) tick();

        // reset mid-stream with three words stored
        out_ready = 1'b0;
        push_word(5'd3, 8'd1);
        push_word(5'd4, 8'd2);
        push_word(5'd5, 8'd3);
        check("mid_count", 32'(count), 32'd3);
        rst      = 1'b1;
        in_valid = 1'b1;
        opcode   = 5'd6;
        imm      = 8'd4;
        repeat (2) tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_instr", 32'(instr), 32'd0);
        check("mid_rst_err", 32'(err_ovf), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);

        // random valid/ready traffic
        base = n_acc;
        cyc  = 0;
        while ((n_acc - base) < 1000 && cyc < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            opcode    = 5'($urandom_range(0, 31));
            imm       = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(8, 255))
                                                     : 8'($urandom_range(0, 7));
            tick();
            cyc++;
        end
        check("rand_budget", 32'((n_acc - base) >= 1000), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
